// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame-buffer read path.
// Holds the pixel/word geometry, the default BRAM sizing, and the
// state and buffer-id types used by vga_mem_buff and its read pipe.
package vga_pkg;

  localparam int unsigned PXL_WIDTH      = 3;
  localparam int unsigned PXL_PER_ROW    = 8;
  localparam int unsigned MEM_WIDTH      = PXL_PER_ROW * PXL_WIDTH;
  localparam int unsigned MEM_DEPTH      = 38400;
  localparam int unsigned MEM_ADDR_WIDTH = $clog2(MEM_DEPTH);
  localparam int unsigned ROW_CTR_WIDTH  = $clog2(PXL_PER_ROW);
  localparam int unsigned MEM_RD_LAT     = 1;

  typedef logic [PXL_WIDTH-1:0] pixel_t;

  // Pixel p of a word sits at bits [p*PXL_WIDTH +: PXL_WIDTH].
  typedef logic [PXL_PER_ROW-1:0][PXL_WIDTH-1:0] mem_word_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL_A,
    FILL_B,
    RUN
  } buff_state_t;

  typedef enum logic {
    BUF_A,
    BUF_B
  } buf_id_t;

endpackage

// File: rtl/vga_mem_buff_if.sv
// Bus between the row buffer, the frame BRAM read port and the colour mux.
// Signal names carry the buffer's own direction suffixes.
//   slave  : the row buffer (consumes display counters and BRAM data,
//            drives BRAM enable/address and the pixel outputs)
//   master : the surrounding logic (display timing, BRAM, colour mux)
interface vga_mem_buff_if
  import vga_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_WIDTH
) ();

  logic                     disp_en_i;
  logic [ADDR_W-1:0]        disp_addr_ctr_i;
  logic [ROW_CTR_WIDTH-1:0] disp_pxl_ctr_i;
  mem_word_t                mem_data_i;
  logic                     mem_en_o;
  logic [ADDR_W-1:0]        mem_addr_o;
  logic                     disp_blank_o;
  pixel_t                   disp_pxl_o;
  logic                     underrun_o;

  modport slave (
    input  disp_en_i, disp_addr_ctr_i, disp_pxl_ctr_i, mem_data_i,
    output mem_en_o, mem_addr_o, disp_blank_o, disp_pxl_o, underrun_o
  );

  modport master (
    output disp_en_i, disp_addr_ctr_i, disp_pxl_ctr_i, mem_data_i,
    input  mem_en_o, mem_addr_o, disp_blank_o, disp_pxl_o, underrun_o
  );

endinterface

// File: rtl/vga_mem_rd_pipe.sv
// Tag pipeline for outstanding BRAM reads. Each issued read enters with
// its target buffer and address and emerges LAT cycles later, aligned
// with the BRAM returning that word.
//   clk_i, rstn_i : clock, async active-low reset
//   flush_i       : drop every read in flight (including one entering now)
//   in_*          : read being issued this cycle
//   out_*         : tag of the word on mem_data_i this cycle
//   busy_o        : a read is somewhere in the pipeline
module vga_mem_rd_pipe
  import vga_pkg::*;
#(
  parameter int unsigned LAT    = 1,
  parameter int unsigned ADDR_W = MEM_ADDR_WIDTH
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  input  buf_id_t           in_buf_i,
  input  logic [ADDR_W-1:0] in_addr_i,
  output logic              out_valid_o,
  output buf_id_t           out_buf_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic              busy_o
);

  logic              vld [LAT];
  buf_id_t           bid [LAT];
  logic [ADDR_W-1:0] adr [LAT];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        vld[i] <= 1'b0;
        bid[i] <= BUF_A;
        adr[i] <= '0;
      end
    end else begin
      vld[0] <= in_valid_i && !flush_i;
      bid[0] <= in_buf_i;
      adr[0] <= in_addr_i;
      for (int unsigned i = 1; i < LAT; i++) begin
        vld[i] <= vld[i-1] && !flush_i;
        bid[i] <= bid[i-1];
        adr[i] <= adr[i-1];
      end
    end
  end

  always_comb begin
    busy_o = 1'b0;
    for (int unsigned i = 0; i < LAT; i++) begin
      busy_o = busy_o | vld[i];
    end
  end

  assign out_valid_o = vld[LAT-1];
  assign out_buf_o   = bid[LAT-1];
  assign out_addr_o  = adr[LAT-1];

endmodule

// File: rtl/vga_mem_buff.sv
// Ping-pong row buffer between the frame BRAM and the VGA colour mux.
// Two prefetched words (A/B) are held; the selected one serves one pixel
// per clock. When its last pixel is served the other buffer takes over
// and the consumed one is refilled with the next sequential word.
//   clk_i  : pixel clock
//   rstn_i : async active-low reset
//   bus    : vga_mem_buff_if.slave
//            disp_en_i/disp_addr_ctr_i/disp_pxl_ctr_i : pixel request
//            mem_data_i, mem_en_o, mem_addr_o         : BRAM read port
//            disp_blank_o, disp_pxl_o                 : registered pixel out
//            underrun_o                               : sticky miss flag
module vga_mem_buff #(
  parameter int unsigned MEM_DEPTH  = vga_pkg::MEM_DEPTH,
  parameter int unsigned MEM_RD_LAT = vga_pkg::MEM_RD_LAT
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  vga_mem_buff_if.slave  bus
);

  import vga_pkg::*;

  localparam int unsigned ADDR_W = $clog2(MEM_DEPTH);
  typedef logic [ADDR_W-1:0] addr_t;

  buff_state_t state, state_nxt;
  addr_t       fetch_ptr, fetch_ptr_inc;
  mem_word_t   buf_a, buf_b, sel_word;
  addr_t       addr_a, addr_b, sel_addr;
  logic        valid_a, valid_b, sel_valid;
  buf_id_t     sel, issue_buf;
  logic        refill_req;
  logic        mem_en;
  logic        hit, miss, consume, resync;
  logic        ret_valid, rd_busy;
  buf_id_t     ret_buf;
  addr_t       ret_addr;
  logic        disp_blank_q, underrun_q;
  pixel_t      disp_pxl_q;

  vga_mem_rd_pipe #(
    .LAT    (MEM_RD_LAT),
    .ADDR_W (ADDR_W)
  ) u_rd_pipe (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .flush_i     (resync),
    .in_valid_i  (mem_en),
    .in_buf_i    (issue_buf),
    .in_addr_i   (fetch_ptr),
    .out_valid_o (ret_valid),
    .out_buf_o   (ret_buf),
    .out_addr_o  (ret_addr),
    .busy_o      (rd_busy)
  );

  always_comb begin
    sel_word  = (sel == BUF_A) ? buf_a   : buf_b;
    sel_addr  = (sel == BUF_A) ? addr_a  : addr_b;
    sel_valid = (sel == BUF_A) ? valid_a : valid_b;
    hit       = (state == RUN) && bus.disp_en_i && sel_valid &&
                (sel_addr == bus.disp_addr_ctr_i);
    miss      = (state == RUN) && bus.disp_en_i && !hit;
    consume   = hit && (bus.disp_pxl_ctr_i == ROW_CTR_WIDTH'(PXL_PER_ROW - 1));
    // Start-of-frame request that misses: display and buffer have lost sync.
    resync    = miss && (bus.disp_addr_ctr_i == '0) && (bus.disp_pxl_ctr_i == '0);
    fetch_ptr_inc = (fetch_ptr == addr_t'(MEM_DEPTH - 1)) ? '0 : fetch_ptr + 1'b1;
  end

  // Fill states issue only when nothing is in flight and the target is
  // still empty, so each read is a single-cycle enable pulse.
  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    issue_buf = BUF_A;
    unique case (state)
      IDLE: state_nxt = FILL_A;
      FILL_A: begin
        if (ret_valid && ret_buf == BUF_A) begin
          state_nxt = FILL_B;
        end else if (!rd_busy && !valid_a) begin
          mem_en = 1'b1;
        end
      end
      FILL_B: begin
        issue_buf = BUF_B;
        if (ret_valid && ret_buf == BUF_B) begin
          state_nxt = RUN;
        end else if (!rd_busy && !valid_b) begin
          mem_en = 1'b1;
        end
      end
      RUN: begin
        // sel has already toggled, so the consumed buffer is the other one.
        mem_en    = refill_req;
        issue_buf = (sel == BUF_A) ? BUF_B : BUF_A;
        if (resync) state_nxt = FILL_A;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      fetch_ptr  <= '0;
      sel        <= BUF_A;
      refill_req <= 1'b0;
      valid_a    <= 1'b0;
      valid_b    <= 1'b0;
      addr_a     <= '0;
      addr_b     <= '0;
      buf_a      <= '0;
      buf_b      <= '0;
    end else if (resync) begin
      fetch_ptr  <= '0;
      sel        <= BUF_A;
      refill_req <= 1'b0;
      valid_a    <= 1'b0;
      valid_b    <= 1'b0;
    end else begin
      if (mem_en) fetch_ptr <= fetch_ptr_inc;
      refill_req <= consume;
      if (ret_valid) begin
        if (ret_buf == BUF_A) begin
          buf_a   <= bus.mem_data_i;
          addr_a  <= ret_addr;
          valid_a <= 1'b1;
        end else begin
          buf_b   <= bus.mem_data_i;
          addr_b  <= ret_addr;
          valid_b <= 1'b1;
        end
      end
      if (consume) begin
        sel <= (sel == BUF_A) ? BUF_B : BUF_A;
        if (sel == BUF_A) valid_a <= 1'b0;
        else              valid_b <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      disp_blank_q <= 1'b1;
      disp_pxl_q   <= '0;
      underrun_q   <= 1'b0;
    end else begin
      disp_blank_q <= !hit;
      disp_pxl_q   <= hit ? sel_word[bus.disp_pxl_ctr_i] : '0;
      if (miss) underrun_q <= 1'b1;
    end
  end

  assign bus.mem_en_o     = mem_en;
  assign bus.mem_addr_o   = fetch_ptr;
  assign bus.disp_blank_o = disp_blank_q;
  assign bus.disp_pxl_o   = disp_pxl_q;
  assign bus.underrun_o   = underrun_q;

endmodule

// File: tb/tb_vga_mem_buff.sv
// Bench for vga_mem_buff with a small frame and a two-cycle BRAM.
// BRAM word k holds pixel p = (k+p) mod 8. The reference model tracks
// which word the display may currently hit, when serving starts after a
// fill, and which reads must appear on which cycle.
module tb_vga_mem_buff;
  import vga_pkg::*;

  localparam int unsigned D  = 64;
  localparam int unsigned L  = 2;
  localparam int unsigned AW = $clog2(D);
  localparam int unsigned NPV = 1 << PXL_WIDTH;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  vga_mem_buff_if #(.ADDR_W(AW)) bus ();

  vga_mem_buff #(
    .MEM_DEPTH  (D),
    .MEM_RD_LAT (L)
  ) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  function automatic mem_word_t word_of(int unsigned k);
    mem_word_t w;
    for (int unsigned p = 0; p < PXL_PER_ROW; p++) w[p] = pixel_t'((k + p) % NPV);
    return w;
  endfunction

  // BRAM: address sampled on the clock after the enable, data L cycles on;
  // junk is presented whenever no read is returning.
  mem_word_t rd_q [L];
  always @(posedge clk) begin
    rd_q[0] <= bus.mem_en_o ? word_of(bus.mem_addr_o) : mem_word_t'($urandom);
    for (int i = 1; i < L; i++) rd_q[i] <= rd_q[i-1];
  end
  assign bus.mem_data_i = rd_q[L-1];

  typedef struct {
    int unsigned cyc;
    int unsigned addr;
  } rd_t;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;
  int unsigned run_at   = 0;
  int unsigned base     = 0;
  bit          m_underrun = 1'b0;
  rd_t         exp_rd [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, want, cyc);
  endtask

  // A fill reads word 0 at t0, word 1 once word 0 has landed, and serving
  // starts once word 1 has landed.
  task automatic start_fill(input int unsigned t0);
    exp_rd.delete();
    exp_rd.push_back('{t0, 0});
    exp_rd.push_back('{t0 + L + 1, 1});
    run_at = t0 + 2 * L + 2;
    base   = 0;
  endtask

  task automatic chk_reset();
    chk("rst_mem_en",   32'(bus.mem_en_o),     32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr_o),   32'd0);
    chk("rst_blank",    32'(bus.disp_blank_o), 32'd1);
    chk("rst_pixel",    32'(bus.disp_pxl_o),   32'd0);
    chk("rst_underrun", 32'(bus.underrun_o),   32'd0);
  endtask

  task automatic step(input bit en, input int unsigned a, input int unsigned p);
    int unsigned in_cyc;
    bit          hit;
    bit          e_en;
    int unsigned e_pxl;
    bus.disp_en_i       = en;
    bus.disp_addr_ctr_i = AW'(a);
    bus.disp_pxl_ctr_i  = ROW_CTR_WIDTH'(p);
    @(posedge clk);
    in_cyc = cyc;
    cyc++;
    #1;
    hit   = en && (in_cyc >= run_at) && (a == base);
    e_pxl = hit ? (a + p) % NPV : 0;
    if (en && (in_cyc >= run_at) && !hit) begin
      m_underrun = 1'b1;
      if (a == 0 && p == 0) start_fill(cyc);
    end else if (hit && p == PXL_PER_ROW - 1) begin
      base = (base + 1) % D;
      exp_rd.push_back('{cyc, (base + 1) % D});
    end
    chk("blank",    32'(bus.disp_blank_o), 32'(!hit));
    chk("pixel",    32'(bus.disp_pxl_o),   e_pxl);
    chk("underrun", 32'(bus.underrun_o),   32'(m_underrun));
    e_en = (exp_rd.size() > 0) && (exp_rd[0].cyc == cyc);
    chk("mem_en", 32'(bus.mem_en_o), 32'(e_en));
    if (e_en) begin
      chk("mem_addr", 32'(bus.mem_addr_o), exp_rd[0].addr);
      void'(exp_rd.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic wait_fill();
    while (cyc < run_at) step(1'($urandom_range(0, 1)), 0, 0);
  endtask

  task automatic stream(input int unsigned first, input int unsigned nwords, input bit gaps);
    for (int unsigned w = first; w < first + nwords; w++) begin
      for (int unsigned p = 0; p < PXL_PER_ROW; p++) begin
        if (gaps && $urandom_range(0, 15) == 0)
          repeat ($urandom_range(1, 6)) step(1'b0, $urandom_range(0, D - 1), $urandom_range(0, 7));
        step(1'b1, w % D, p);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.disp_en_i       = 1'b0;
    bus.disp_addr_ctr_i = '0;
    bus.disp_pxl_ctr_i  = '0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset();

    // Initial fill from reset release.
    rstn = 1'b1;
    start_fill(cyc + 1);
    wait_fill();

    // Sequential words 0,1 then the rest of the frame and across the wrap,
    // with random idle gaps and one long blanking interval.
    stream(0, 2, 1'b0);
    stream(2, D / 2 - 2, 1'b1);
    repeat (160) step(1'b0, $urandom_range(0, D - 1), $urandom_range(0, 7));
    stream(D / 2, D / 2 + 3, 1'b1);

    // Out-of-window requests: sticky underrun.
    step(1'b1, (base + 5) % D, 3);
    repeat (4) step(1'b1, (base + 2 + $urandom_range(0, D - 4)) % D, $urandom_range(1, 7));
    stream(base, 1, 1'b0);

    // Frame restart while desynchronised forces a refill from word 0.
    step(1'b1, 0, 0);
    wait_fill();
    stream(0, 6, 1'b1);

    // Reset while a refill read is in flight.
    stream(base, 1, 1'b0);
    step(1'b1, base, 0);
    #2;
    rstn = 1'b0;
    bus.disp_en_i = 1'b0;
    #1;
    chk_reset();
    m_underrun = 1'b0;
    exp_rd.delete();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    start_fill(cyc + 1);
    wait_fill();
    stream(0, 4, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
